// File: rtl/collision_scan_pkg.sv
// Shared types and sizing helpers for the snake collision scanner.
// Build option: define COLLISION_SELF_EN to let a snake collide with its own body.
package snake_pkg;

  localparam int DEF_COORD_W = 10;
  localparam int DEF_MAX_LEN = 16;

  // Length fields must be able to hold MAX_LEN itself, hence the +1.
  function automatic int len_w(input int max_len);
    return $clog2(max_len + 1);
  endfunction

  function automatic int idx_w(input int max_len);
    return (max_len > 1) ? $clog2(max_len) : 1;
  endfunction

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/collision_scan_if.sv
// Request/result bundle between the game-control FSM and collision_scan.
// Build option: COLLISION_SELF_EN (consumed by the scanner, not by this interface).
interface collision_scan_if
  import snake_pkg::*;
#(
  parameter int NUM_SNAKES = 2,
  parameter int MAX_LEN    = DEF_MAX_LEN,
  parameter int COORD_W    = DEF_COORD_W
);
  localparam int LEN_W = len_w(MAX_LEN);

  logic                                  start;
  logic [NUM_SNAKES*MAX_LEN*COORD_W-1:0] bodies;
  logic [NUM_SNAKES*LEN_W-1:0]           lens;
  logic                                  busy;
  logic                                  done;
  logic [NUM_SNAKES-1:0]                 hit;

  modport master (
    output start, bodies, lens,
    input  busy, done, hit
  );

  modport slave (
    input  start, bodies, lens,
    output busy, done, hit
  );

endinterface

// File: rtl/collision_scan_head_seg_cmp.sv
// Compares every snake head against one segment column (same index in every body).
// Build option: COLLISION_SELF_EN unmasks a head against its own body (index >= 1).
module head_seg_cmp
  import snake_pkg::*;
#(
  parameter int NUM_SNAKES = 2,
  parameter int COORD_W    = DEF_COORD_W,
  parameter int LEN_W      = len_w(DEF_MAX_LEN),
  parameter int IDX_W      = idx_w(DEF_MAX_LEN)
) (
  input  logic [NUM_SNAKES*COORD_W-1:0] i_heads,
  input  logic [NUM_SNAKES*COORD_W-1:0] i_col,
  input  logic [IDX_W-1:0]              i_seg_idx,
  input  logic [NUM_SNAKES*LEN_W-1:0]   i_lens,
  output logic [NUM_SNAKES-1:0]         o_match
);

`ifdef COLLISION_SELF_EN
  localparam bit SELF_EN = 1'b1;
`else
  localparam bit SELF_EN = 1'b0;
`endif

  logic [LEN_W-1:0] w_seg_ext;
  logic             w_seg_zero;

  assign w_seg_ext  = LEN_W'(i_seg_idx);
  assign w_seg_zero = (i_seg_idx == '0);

  genvar gi, gk;
  generate
    for (gi = 0; gi < NUM_SNAKES; gi++) begin : g_head
      logic [NUM_SNAKES-1:0] w_pair;
      logic                  w_head_live;

      assign w_head_live = (i_lens[gi*LEN_W +: LEN_W] != '0);

      for (gk = 0; gk < NUM_SNAKES; gk++) begin : g_seg
        localparam bit SAME = (gi == gk);
        logic w_in_len;
        logic w_eq;
        logic w_masked;

        // A zero length makes w_in_len false, so absent snakes never match.
        assign w_in_len    = (w_seg_ext < i_lens[gk*LEN_W +: LEN_W]);
        assign w_eq        = (i_col[gk*COORD_W +: COORD_W] == i_heads[gi*COORD_W +: COORD_W]);
        assign w_masked    = SAME && (!SELF_EN || w_seg_zero);
        assign w_pair[gk]  = w_head_live && w_in_len && w_eq && !w_masked;
      end

      assign o_match[gi] = |w_pair;
    end
  endgenerate

endmodule

// File: rtl/collision_scan.sv
// Snapshots all snake bodies on start, then walks one segment index per cycle collecting head hits.
// Build option: COLLISION_SELF_EN (self-body collisions, handled in head_seg_cmp).
module collision_scan
  import snake_pkg::*;
#(
  parameter int NUM_SNAKES = 2,
  parameter int MAX_LEN    = DEF_MAX_LEN,
  parameter int COORD_W    = DEF_COORD_W
) (
  input logic              clk,
  input logic              rst_n,
  collision_scan_if.slave  bus
);

  localparam int LEN_W  = len_w(MAX_LEN);
  localparam int IDX_W  = idx_w(MAX_LEN);
  localparam int BODY_W = NUM_SNAKES * MAX_LEN * COORD_W;
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(MAX_LEN - 1);
  localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);

  state_t                      r_state;
  state_t                      w_state_next;
  logic [IDX_W-1:0]            r_seg_idx;
  logic [IDX_W-1:0]            w_seg_idx_next;
  logic [BODY_W-1:0]           r_bodies;
  logic [NUM_SNAKES*LEN_W-1:0] r_lens;
  logic [NUM_SNAKES*LEN_W-1:0] w_lens_sat;
  logic [NUM_SNAKES-1:0]       r_hit;
  logic [NUM_SNAKES-1:0]       w_hit_next;
  logic [NUM_SNAKES-1:0]       w_match;
  logic                        w_snap;
  logic [NUM_SNAKES*COORD_W-1:0] w_heads;
  logic [NUM_SNAKES*COORD_W-1:0] w_col;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_SNAKES; gi++) begin : g_snake
      logic [LEN_W-1:0] w_len_in;

      assign w_len_in = bus.lens[gi*LEN_W +: LEN_W];
      // Oversized lengths clamp so the scan never reads past a body buffer.
      assign w_lens_sat[gi*LEN_W +: LEN_W] = (w_len_in > MAX_LEN_L) ? MAX_LEN_L : w_len_in;
      assign w_heads[gi*COORD_W +: COORD_W] = r_bodies[gi*MAX_LEN*COORD_W +: COORD_W];
      assign w_col[gi*COORD_W +: COORD_W] =
        r_bodies[(gi*MAX_LEN + int'(r_seg_idx))*COORD_W +: COORD_W];
    end
  endgenerate

  head_seg_cmp #(
    .NUM_SNAKES (NUM_SNAKES),
    .COORD_W    (COORD_W),
    .LEN_W      (LEN_W),
    .IDX_W      (IDX_W)
  ) u_cmp (
    .i_heads   (w_heads),
    .i_col     (w_col),
    .i_seg_idx (r_seg_idx),
    .i_lens    (r_lens),
    .o_match   (w_match)
  );

  always_comb begin
    w_state_next   = r_state;
    w_seg_idx_next = r_seg_idx;
    w_hit_next     = r_hit;
    w_snap         = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.start) begin
          w_snap         = 1'b1;
          w_hit_next     = '0;
          w_seg_idx_next = '0;
          w_state_next   = SCAN;
        end
      end
      SCAN: begin
        w_hit_next = r_hit | w_match;
        if (r_seg_idx == LAST_IDX) begin
          w_state_next = DONE;
        end else begin
          w_seg_idx_next = r_seg_idx + 1'b1;
        end
      end
      DONE: begin
        w_state_next = IDLE;
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_seg_idx <= '0;
      r_hit     <= '0;
      r_bodies  <= '0;
      r_lens    <= '0;
    end else begin
      r_state   <= w_state_next;
      r_seg_idx <= w_seg_idx_next;
      r_hit     <= w_hit_next;
      if (w_snap) begin
        r_bodies <= bus.bodies;
        r_lens   <= w_lens_sat;
      end
    end
  end

  assign bus.busy = (r_state != IDLE);
  assign bus.done = (r_state == DONE);
  assign bus.hit  = r_hit;

endmodule

// File: tb/tb_collision_scan.sv
// Scoreboard bench for collision_scan (three snakes, 16 segments); honours COLLISION_SELF_EN.
module tb_collision_scan;
  import snake_pkg::*;

  localparam int NS = 3;
  localparam int ML = 16;
  localparam int CW = 10;
  localparam int LW = len_w(ML);

`ifdef COLLISION_SELF_EN
  localparam bit SELF = 1'b1;
`else
  localparam bit SELF = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  collision_scan_if #(.NUM_SNAKES(NS), .MAX_LEN(ML), .COORD_W(CW)) bus ();

  collision_scan #(.NUM_SNAKES(NS), .MAX_LEN(ML), .COORD_W(CW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  typedef struct {
    logic [NS-1:0] hit;
    int            cyc;
  } exp_t;

  exp_t          sb_q[$];
  int            n_vec = 0;
  int            n_err = 0;
  bit            mon_en = 1'b0;
  logic [CW-1:0] seg_a [NS][ML];
  int            len_a [NS];

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic fill_default();
    for (int k = 0; k < NS; k++) begin
      len_a[k] = 0;
      for (int j = 0; j < ML; j++) seg_a[k][j] = CW'(12'h200 + k*32 + j);
    end
  endtask

  task automatic drive_bus();
    for (int k = 0; k < NS; k++) begin
      bus.lens[k*LW +: LW] = LW'(len_a[k]);
      for (int j = 0; j < ML; j++) bus.bodies[(k*ML+j)*CW +: CW] = seg_a[k][j];
    end
  endtask

  // Reference: walk each live head over every in-range segment of every snake.
  function automatic logic [NS-1:0] model();
    logic [NS-1:0] r = '0;
    for (int i = 0; i < NS; i++) begin
      if (len_a[i] == 0) continue;
      for (int k = 0; k < NS; k++) begin
        int lk = (len_a[k] > ML) ? ML : len_a[k];
        for (int j = 0; j < lk; j++) begin
          if (k == i && (j == 0 || !SELF)) continue;
          if (seg_a[k][j] == seg_a[i][0]) r[i] = 1'b1;
        end
      end
    end
    return r;
  endfunction

  // Done must appear MAX_LEN cycles after busy first shows.
  task automatic start_scan(input logic [NS-1:0] exp);
    @(negedge clk);
    drive_bus();
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    sb_q.push_back(exp_t'{hit: exp, cyc: cyc + ML});
    check_val("busy_on", 32'(bus.busy), 32'd1);
  endtask

  task automatic wait_done();
    for (int i = 0; i < ML + 8 && sb_q.size() != 0; i++) begin
      @(negedge clk);
      #1;
    end
    check_val("done_pending", 32'(sb_q.size()), 32'd0);
    sb_q.delete();
  endtask

  task automatic run(input string name, input logic [NS-1:0] exp);
    $display("scan %s: lens=%0d/%0d/%0d expect hit=%b", name, len_a[0], len_a[1], len_a[2], exp);
    start_scan(exp);
    wait_done();
    repeat (2) @(negedge clk);
    check_val({name, "_hold"}, 32'(bus.hit), 32'(exp));
    check_val({name, "_idle"}, 32'(bus.busy), 32'd0);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (mon_en && rst_n && bus.done) begin
      if (sb_q.size() == 0) begin
        check_val("done_unexpected", 32'(bus.done), 32'd0);
      end else begin
        e = sb_q.pop_front();
        $display("done at cycle %0d: hit=%b expected=%b", cyc, bus.hit, e.hit);
        check_val("hit", 32'(bus.hit), 32'(e.hit));
        check_val("done_cycle", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    bus.start  = 1'b0;
    bus.bodies = '0;
    bus.lens   = '0;
    fill_default();
    drive_bus();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_val("rst_busy", 32'(bus.busy), 32'd0);
    check_val("rst_done", 32'(bus.done), 32'd0);
    check_val("rst_hit", 32'(bus.hit), 32'd0);
    rst_n  = 1'b1;
    mon_en = 1'b1;

    // Reset in the middle of a scan that has already found its hit.
    fill_default();
    seg_a[0][0] = 10'h055; seg_a[1][2] = 10'h055;
    len_a[0] = 4; len_a[1] = 4;
    start_scan(3'b001);
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    sb_q.delete();
    check_val("abort_busy", 32'(bus.busy), 32'd0);
    check_val("abort_hit", 32'(bus.hit), 32'd0);
    check_val("abort_done", 32'(bus.done), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (ML + 4) @(negedge clk);
    run("after_abort", 3'b001);

    fill_default();
    seg_a[0][0] = 10'h055; seg_a[1][2] = 10'h055;
    len_a[0] = 4; len_a[1] = 4;
    run("inter_body", 3'b001);

    fill_default();
    seg_a[0][0] = 10'h100; seg_a[1][0] = 10'h100; seg_a[2][0] = 10'h100;
    len_a[0] = 4; len_a[1] = 4; len_a[2] = 0;
    run("head_to_head", 3'b011);

    fill_default();
    seg_a[0][0] = 10'h0AA; seg_a[1][5] = 10'h0AA;
    len_a[0] = 4; len_a[1] = 5;
    run("len_mask5", 3'b000);
    len_a[1] = 6;
    run("len_mask6", 3'b001);

    fill_default();
    seg_a[0][0] = 10'h0CC; seg_a[0][3] = 10'h0CC;
    len_a[0] = 8; len_a[1] = 4;
    run("self_bite", SELF ? 3'b001 : 3'b000);

    fill_default();
    seg_a[0][0] = 10'h0EE; seg_a[1][15] = 10'h0EE;
    len_a[0] = 4; len_a[1] = 15;
    run("len15_last", 3'b000);
    len_a[1] = 31;
    run("len_saturate", 3'b001);

    // Snapshot isolation: new bodies and extra starts while busy and in DONE.
    fill_default();
    seg_a[0][0] = 10'h055; seg_a[1][2] = 10'h055;
    len_a[0] = 4; len_a[1] = 4;
    $display("scan isolation: expect hit=001 and a single done");
    start_scan(3'b001);
    repeat (2) @(negedge clk);
    seg_a[1][2] = 10'h3FF;
    seg_a[2][0] = 10'h201; len_a[2] = 4;
    drive_bus();
    bus.start = 1'b1;
    repeat (2) @(negedge clk);
    bus.start = 1'b0;
    wait_done();
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    #1;
    check_val("iso_start_in_done", 32'(bus.busy), 32'd0);
    repeat (ML + 4) @(negedge clk);
    check_val("iso_hit", 32'(bus.hit), 32'd1);

    for (int t = 0; t < 8; t++) begin
      for (int k = 0; k < NS; k++) begin
        len_a[k] = $urandom_range(0, 20);
        for (int j = 0; j < ML; j++) seg_a[k][j] = CW'($urandom_range(0, 15));
      end
      run("random", model());
    end

    mon_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
